// File: rtl/fibonacci_checker.sv
// Receive-side monitor for a Fibonacci term stream: checks each accepted beat against the
// running modulo-2^W sequence and latches the first offending beat.
module fibonacci_checker #(
    parameter int unsigned     W     = 32,
    parameter int unsigned     CNT_W = 6,
    parameter logic [W-1:0]    SEED  = {{(W-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [W-1:0]     in_w,
    output logic             in_rdy,
    output logic             res_vld,
    output logic             res_ok,
    output logic [CNT_W-1:0] idx,
    output logic             fault,
    output logic [CNT_W-1:0] err_idx,
    output logic [W-1:0]     err_exp,
    output logic [W-1:0]     err_got
);

    typedef enum logic [1:0] {StSeed0, StSeed1, StTrack, StFault} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       x0_q, x0_d;
    logic [W-1:0]       x1_q, x1_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   err_idx_q, err_idx_d;
    logic [W-1:0]       err_exp_q, err_exp_d;
    logic [W-1:0]       err_got_q, err_got_d;
    logic               res_vld_q, res_vld_d;
    logic               res_ok_q, res_ok_d;
    logic               alive_q;

    logic [W-1:0]       exp_w;
    logic               match;
    logic               accept;

    // Holds in_rdy low while in reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign in_rdy = alive_q & ~clr & (state_q != StFault);
    assign accept = in_vld & in_rdy;

    always_comb begin
        exp_w = SEED;
        unique case (state_q)
            StSeed0: exp_w = SEED;
            StSeed1: exp_w = SEED;
            StTrack: exp_w = x0_q + x1_q;
            StFault: exp_w = SEED;
            default: exp_w = SEED;
        endcase
    end

    assign match = (in_w == exp_w);

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        idx_d     = idx_q;
        fault_d   = fault_q;
        err_idx_d = err_idx_q;
        err_exp_d = err_exp_q;
        err_got_d = err_got_q;
        res_vld_d = 1'b0;
        res_ok_d  = 1'b0;

        if (clr) begin
            state_d   = StSeed0;
            x0_d      = '0;
            x1_d      = '0;
            idx_d     = '0;
            fault_d   = 1'b0;
            err_idx_d = '0;
            err_exp_d = '0;
            err_got_d = '0;
        end else if (accept) begin
            res_vld_d = 1'b1;
            res_ok_d  = match;
            if (idx_q != {CNT_W{1'b1}}) begin
                idx_d = idx_q + 1'b1;
            end
            if (match) begin
                unique case (state_q)
                    StSeed0: begin
                        x0_d    = in_w;
                        state_d = StSeed1;
                    end
                    StSeed1: begin
                        x1_d    = in_w;
                        state_d = StTrack;
                    end
                    StTrack: begin
                        x0_d = x1_q;
                        x1_d = in_w;
                    end
                    StFault: state_d = StFault;
                    default: state_d = StFault;
                endcase
            end else begin
                state_d   = StFault;
                fault_d   = 1'b1;
                err_idx_d = idx_q;
                err_exp_d = exp_w;
                err_got_d = in_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StSeed0;
            x0_q      <= '0;
            x1_q      <= '0;
            idx_q     <= '0;
            fault_q   <= 1'b0;
            err_idx_q <= '0;
            err_exp_q <= '0;
            err_got_q <= '0;
            res_vld_q <= 1'b0;
            res_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            idx_q     <= idx_d;
            fault_q   <= fault_d;
            err_idx_q <= err_idx_d;
            err_exp_q <= err_exp_d;
            err_got_q <= err_got_d;
            res_vld_q <= res_vld_d;
            res_ok_q  <= res_ok_d;
        end
    end

    assign res_vld = res_vld_q;
    assign res_ok  = res_ok_q;
    assign idx     = idx_q;
    assign fault   = fault_q;
    assign err_idx = err_idx_q;
    assign err_exp = err_exp_q;
    assign err_got = err_got_q;

endmodule
